// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture/decode slice.
// Segment patterns use bit7 = dp and bits6:0 = g..a.
package seg7_pkg;

  localparam logic [7:0] SEG_ZERO    = 8'h3F;
  localparam logic [7:0] SEG_UNO     = 8'h06;
  localparam logic [7:0] SEG_DUE     = 8'h5B;
  localparam logic [7:0] SEG_TRE     = 8'h4F;
  localparam logic [7:0] SEG_QUATTRO = 8'h66;
  localparam logic [7:0] SEG_CINQUE  = 8'h6D;
  localparam logic [7:0] SEG_SEI     = 8'h7D;
  localparam logic [7:0] SEG_SETTE   = 8'h07;
  localparam logic [7:0] SEG_OTTO    = 8'h7F;
  localparam logic [7:0] SEG_NOVE    = 8'h6F;
  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP      = 8'h80;

  typedef enum logic [1:0] {
    BLANK    = 2'd0,
    SETTLING = 2'd1,
    LOCKED   = 2'd2,
    ERROR    = 2'd3
  } seg_state_t;

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// Segment bus plus decoded result fields; master drives the pattern,
// slave (the decoder) returns the committed digit, flags, history and count.
interface seg7_capture_decoder_if #(
  parameter int NBITS_TOP  = 8,
  parameter int HIST_DEPTH = 4
);
  logic [NBITS_TOP-1:0]    seg_in;
  logic [3:0]              digit;
  logic                    dp;
  logic                    digit_valid;
  logic                    err_pattern;
  logic                    blank;
  logic [4*HIST_DEPTH-1:0] hist;
  logic [7:0]              change_count;

  modport master (
    output seg_in,
    input  digit, dp, digit_valid, err_pattern, blank, hist, change_count
  );

  modport slave (
    input  seg_in,
    output digit, dp, digit_valid, err_pattern, blank, hist, change_count
  );
endinterface

// File: rtl/seg7_lut.sv
// Reverse seven-segment lookup: bits g..a back to a BCD digit.
// This is the single home of the decode table.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    is_blank = (pattern == SEG_BLANK[6:0]);
    case (pattern)
      SEG_ZERO[6:0]:    digit = 4'd0;
      SEG_UNO[6:0]:     digit = 4'd1;
      SEG_DUE[6:0]:     digit = 4'd2;
      SEG_TRE[6:0]:     digit = 4'd3;
      SEG_QUATTRO[6:0]: digit = 4'd4;
      SEG_CINQUE[6:0]:  digit = 4'd5;
      SEG_SEI[6:0]:     digit = 4'd6;
      SEG_SETTE[6:0]:   digit = 4'd7;
      SEG_OTTO[6:0]:    digit = 4'd8;
      SEG_NOVE[6:0]:    digit = 4'd9;
      default:          is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a segment bus, commits a pattern once it has held for STABLE_CYCLES
// edges, decodes it and keeps a digit history and a saturating commit counter.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NBITS_TOP     = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int HIST_DEPTH    = 4
) (
  input  logic                   clk_2,
  input  logic                   reset,
  seg7_capture_decoder_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam int         HW       = 4 * HIST_DEPTH;

  logic [NBITS_TOP-1:0] seg_q, seg_d;
  logic [NBITS_TOP-1:0] last_seg_q, last_seg_d;
  logic [7:0]           cnt_q, cnt_d;
  seg_state_t           state_q, state_d;
  logic [3:0]           digit_q, digit_d;
  logic                 dp_q, dp_d;
  logic                 digit_valid_q, digit_valid_d;
  logic                 err_pattern_q, err_pattern_d;
  logic                 blank_q, blank_d;
  logic [HW-1:0]        hist_q, hist_d;
  logic [7:0]           change_count_q, change_count_d;

  logic [3:0] lut_digit;
  logic       lut_is_digit;
  logic       lut_is_blank;

  // Decode the registered sample; at commit it equals seg_in by definition.
  seg7_lut u_lut (
    .pattern  (seg_q[6:0]),
    .digit    (lut_digit),
    .is_digit (lut_is_digit),
    .is_blank (lut_is_blank)
  );

  always_comb begin
    seg_d          = bus.seg_in;
    last_seg_d     = last_seg_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    digit_d        = digit_q;
    dp_d           = dp_q;
    digit_valid_d  = 1'b0;
    err_pattern_d  = 1'b0;
    blank_d        = blank_q;
    hist_d         = hist_q;
    change_count_d = change_count_q;

    if (bus.seg_in != seg_q) begin
      cnt_d   = 8'd0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 8'd1;
      end else if (lut_is_blank) begin
        state_d = BLANK;
        blank_d = 1'b1;
      end else if (lut_is_digit) begin
        state_d = LOCKED;
        blank_d = 1'b0;
        // Re-committing the last accepted pattern is silent.
        if (seg_q != last_seg_q) begin
          digit_d       = lut_digit;
          dp_d          = seg_q[NBITS_TOP-1];
          digit_valid_d = 1'b1;
          hist_d        = hist_q << 4;
          hist_d[3:0]   = lut_digit;
          last_seg_d    = seg_q;
          if (change_count_q != 8'hFF) change_count_d = change_count_q + 8'd1;
        end
      end else begin
        state_d       = ERROR;
        blank_d       = 1'b0;
        err_pattern_d = 1'b1;
        last_seg_d    = seg_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      seg_q          <= SEG_BLANK[NBITS_TOP-1:0];
      last_seg_q     <= SEG_BLANK[NBITS_TOP-1:0];
      cnt_q          <= 8'd0;
      state_q        <= BLANK;
      digit_q        <= 4'd0;
      dp_q           <= 1'b0;
      digit_valid_q  <= 1'b0;
      err_pattern_q  <= 1'b0;
      blank_q        <= 1'b1;
      hist_q         <= '0;
      change_count_q <= 8'd0;
    end else begin
      seg_q          <= seg_d;
      last_seg_q     <= last_seg_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      digit_q        <= digit_d;
      dp_q           <= dp_d;
      digit_valid_q  <= digit_valid_d;
      err_pattern_q  <= err_pattern_d;
      blank_q        <= blank_d;
      hist_q         <= hist_d;
      change_count_q <= change_count_d;
    end
  end

  assign bus.digit        = digit_q;
  assign bus.dp           = dp_q;
  assign bus.digit_valid  = digit_valid_q;
  assign bus.err_pattern  = err_pattern_q;
  assign bus.blank        = blank_q;
  assign bus.hist         = hist_q;
  assign bus.change_count = change_count_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: stimulus pushes expected commits into
// a queue, a monitor pops and compares on every digit_valid/err_pattern pulse.
module tb_seg7_capture_decoder;
  import seg7_pkg::*;

  localparam int STABLE = 4;
  localparam int HD     = 4;

  logic clk_2 = 1'b0;
  logic reset = 1'b1;

  seg7_capture_decoder_if #(.NBITS_TOP(8), .HIST_DEPTH(HD)) bus ();

  seg7_capture_decoder #(
    .NBITS_TOP     (8),
    .STABLE_CYCLES (STABLE),
    .HIST_DEPTH    (HD)
  ) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    int         kind;     // 0 none, 1 digit pulse, 2 error pulse
    int         edge_no;
    logic [3:0] digit;
    logic       dp;
    logic [15:0] hist;
    logic [7:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_n   = 0;

  always @(posedge clk_2) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
  endtask

  function automatic exp_t mk(input int kind, input logic [3:0] d, input logic p,
                              input logic [15:0] h, input logic [7:0] c);
    exp_t e;
    e.kind = kind; e.edge_no = 0; e.digit = d; e.dp = p; e.hist = h; e.count = c;
    return e;
  endfunction

  // Drive a pattern on a falling edge and hold it for n rising edges; if a
  // commit pulse is expected it lands STABLE edges after the capture edge.
  task automatic apply(input logic [7:0] pat, input int n, input exp_t e);
    @(negedge clk_2);
    bus.seg_in = pat;
    if (e.kind != 0) begin
      e.edge_no = edge_n + 1 + STABLE;
      exp_q.push_back(e);
    end
    repeat (n) @(posedge clk_2);
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk_2) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missed_pulse: got no pulse at edge %0d, required kind %0d digit %0h",
               mon_e.edge_no, mon_e.kind, mon_e.digit);
    end
    if (bus.digit_valid || bus.err_pattern) begin
      check("pulse_exclusive", {31'd0, bus.digit_valid & bus.err_pattern}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got dv=%0b err=%0b at edge %0d, required none",
                 bus.digit_valid, bus.err_pattern, edge_n);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_edge",  edge_n, mon_e.edge_no);
        check("pulse_kind",  {30'd0, bus.err_pattern, bus.digit_valid}, (mon_e.kind == 2) ? 32'd2 : 32'd1);
        check("pulse_digit", {28'd0, bus.digit}, {28'd0, mon_e.digit});
        check("pulse_dp",    {31'd0, bus.dp}, {31'd0, mon_e.dp});
        check("pulse_hist",  {16'd0, bus.hist}, {16'd0, mon_e.hist});
        check("pulse_count", {24'd0, bus.change_count}, {24'd0, mon_e.count});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_digit"}, {28'd0, bus.digit}, 32'd0);
    check({tag, "_dp"},    {31'd0, bus.dp}, 32'd0);
    check({tag, "_dv"},    {31'd0, bus.digit_valid}, 32'd0);
    check({tag, "_err"},   {31'd0, bus.err_pattern}, 32'd0);
    check({tag, "_blank"}, {31'd0, bus.blank}, 32'd1);
    check({tag, "_hist"},  {16'd0, bus.hist}, 32'd0);
    check({tag, "_count"}, {24'd0, bus.change_count}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  exp_t none;
  logic [15:0] hist_m;
  logic [7:0]  cnt_m;
  logic [3:0]  d_m;

  initial begin
    none = mk(0, 4'd0, 1'b0, 16'h0, 8'd0);
    bus.seg_in = 8'h00;
    repeat (2) @(negedge clk_2);
    check_reset_vals("reset");
    reset = 1'b0;

    // 1: first digit
    apply(8'h5B, 6, mk(1, 4'd2, 1'b0, 16'h0002, 8'd1));
    #1 check("t1_blank_clear", {31'd0, bus.blank}, 32'd0);

    // 2: sequence, then one more push drops the oldest digit
    apply(8'h06, 5, mk(1, 4'd1, 1'b0, 16'h0021, 8'd2));
    apply(8'h4F, 5, mk(1, 4'd3, 1'b0, 16'h0213, 8'd3));
    apply(8'h66, 5, mk(1, 4'd4, 1'b0, 16'h2134, 8'd4));
    apply(8'h6D, 5, mk(1, 4'd5, 1'b0, 16'h1345, 8'd5));
    apply(8'h7D, 5, mk(1, 4'd6, 1'b0, 16'h3456, 8'd6));

    // 3: digit with dp, then a short glitch and a silent return
    apply(8'hEF, 6, mk(1, 4'd9, 1'b1, 16'h4569, 8'd7));
    apply(8'h7F, 2, none);
    apply(8'hEF, 8, none);
    #1 check("t3_digit_hold", {28'd0, bus.digit}, 32'd9);
    check("t3_dp_hold", {31'd0, bus.dp}, 32'd1);

    // 4: invalid pattern leaves digit state alone, then blank
    apply(8'h49, 6, mk(2, 4'd9, 1'b1, 16'h4569, 8'd7));
    apply(8'h00, 6, none);
    #1 check("t4_blank", {31'd0, bus.blank}, 32'd1);
    check("t4_digit_hold", {28'd0, bus.digit}, 32'd9);

    // 5: saturation of the commit counter
    hist_m = 16'h4569;
    cnt_m  = 8'd7;
    for (int i = 0; i < 300; i++) begin
      d_m    = (i % 2 == 0) ? 4'd0 : 4'd1;
      hist_m = {hist_m[11:0], d_m};
      cnt_m  = (cnt_m == 8'hFF) ? 8'hFF : cnt_m + 8'd1;
      apply((i % 2 == 0) ? 8'h3F : 8'h06, 5, mk(1, d_m, 1'b0, hist_m, cnt_m));
    end
    #1 check("t5_saturated", {24'd0, bus.change_count}, 32'd255);

    // 6: reset two cycles into a settle; the abandoned settle never pulses.
    // The held pattern is re-captured from the cleared sample register after
    // release and commits as a fresh digit STABLE edges later.
    @(negedge clk_2);
    bus.seg_in = 8'h4F;
    repeat (2) @(negedge clk_2);
    reset = 1'b1;
    #1 check_reset_vals("midsettle_reset");
    repeat (4) @(negedge clk_2);
    check_reset_vals("held_reset");
    reset = 1'b0;
    exp_q.push_back(mk(1, 4'd3, 1'b0, 16'h0003, 8'd1));
    exp_q[exp_q.size()-1].edge_no = edge_n + 1 + STABLE;
    repeat (10) @(negedge clk_2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
